edge_window_counter: RTL and testbench
======================================

Name: edge_window_counter

Overview:
- Downstream consumer of the synchronised rising-edge pulse produced by the edge detection stage.
- Counts single-cycle event pulses over a fixed, back-to-back measurement window of WINDOW_CYCLES clocks.
- Publishes the per-window count with a one-cycle valid strobe and an overflow flag; feeds rate monitoring and status logic.

Parameters:
- WINDOW_CYCLES, 1000, window length in clock cycles; must be >= 2; window counter width = clog2(WINDOW_CYCLES).
- CNT_WIDTH, 8, width of the event counter and count_out; must be >= 1.
- HOLDOFF_CYCLES, 4, ignore interval after an accepted pulse; used only when EDGE_CNT_HOLDOFF_EN is defined; must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level; windows run while high.
- pulse_in  input  1  single-cycle event pulse from the edge detector, already synchronous to clk.
- count_out  output  CNT_WIDTH  event count of the last completed window; held until the next window completes.
- count_valid  output  1  one-cycle strobe; count_out/overflow_out updated in the same cycle.
- overflow_out  output  1  last completed window saturated.
- busy  output  1  high while in COUNT.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - count_out = 0, count_valid = 0, overflow_out = 0, busy = 0.
  - Internal win_cnt = 0, evt_cnt = 0, ovf = 0, state = IDLE.
  - Reset overrides every other input in the same cycle, including mid-window: the partial window is discarded and no count_valid is produced.
- State machine:
  - IDLE:
    - busy = 0; win_cnt = evt_cnt = ovf = 0.
    - Transitions to COUNT on the first cycle enable is sampled high.
    - That cycle is window cycle 0; its pulse_in counts.
  - COUNT:
    - busy = 1.
    - Each enabled cycle processes window cycle index win_cnt.
    - On enable sampled low: go to IDLE, clear win_cnt/evt_cnt/ovf, no count_valid, count_out/overflow_out hold their previous values.
- Counting, in each enabled cycle:
  - If pulse_in = 1 and evt_cnt < 2^CNT_WIDTH-1: evt_cnt += 1.
  - If pulse_in = 1 and evt_cnt = max: evt_cnt holds (saturates) and ovf <= 1, sticky for the window.
  - Non-last cycles: win_cnt += 1.
- Window completion, at the edge where win_cnt = WINDOW_CYCLES-1 with enable high:
  - count_out <= saturating(evt_cnt + pulse_in).
  - overflow_out <= ovf OR (pulse_in AND evt_cnt = max).
  - count_valid <= 1 for exactly one cycle.
  - win_cnt, evt_cnt and ovf cleared.
  - The next window starts on the following cycle with no gap.
- Latency: count_valid is visible in the cycle after the last window cycle. Windows are contiguous, so count_valid repeats every WINDOW_CYCLES cycles while enable stays high.
- Boundary cases:
  - A pulse on the last window cycle belongs to that window.
  - A pulse on the first cycle of the next window belongs to the next window.
- count_valid is 0 in all cycles other than the completion cycle defined above.
- pulse_in is ignored while enable = 0.

Optional Feature:
- Macro: EDGE_CNT_HOLDOFF_EN.
- Defined:
  - After an accepted pulse, pulse_in is ignored for the next HOLDOFF_CYCLES cycles.
  - The holdoff down-counter runs across window boundaries.
  - It is cleared by reset and by enable low.
  - Ignored pulses neither count nor set overflow.
- Not defined:
  - Every pulse_in in an enabled cycle counts.
  - HOLDOFF_CYCLES is unused and no holdoff logic is synthesised.

Test Plan:
- Reset: assert reset 3 cycles with enable = 1 and pulse_in toggling -> count_out = 0, count_valid = 0, overflow_out = 0, busy = 0 throughout.
- Basic window (WINDOW_CYCLES = 16): enable high from cycle 0, pulses on window cycles 2, 7, 11 -> one cycle after window cycle 15: count_valid = 1 for one cycle, count_out = 3, overflow_out = 0; count_valid repeats 16 cycles later.
- Boundary (WINDOW_CYCLES = 16): pulses on window cycle 15 and on cycle 0 of the next window -> first window count_out = 1, second window count_out = 1.
- Saturation (CNT_WIDTH = 2): 5 pulses in one window -> count_out = 3, overflow_out = 1; 1 pulse in the following window -> count_out = 1, overflow_out = 0.
- Abort (WINDOW_CYCLES = 16): 2 pulses, then enable dropped at window cycle 8 -> no count_valid, busy = 0 next cycle, count_out holds its prior value; re-enable -> full 16-cycle window before the next count_valid.
- Holdoff (EDGE_CNT_HOLDOFF_EN, HOLDOFF_CYCLES = 4): pulses on window cycles 0, 2, 5 -> count_out = 2 (pulse on cycle 2 ignored); same stimulus without the macro -> count_out = 3.

Source files
------------

// File: rtl/edge_window_counter.sv
// edge_window_counter
// Counts single-cycle event pulses over back-to-back windows of WINDOW_CYCLES
// clocks and publishes each window's count with a one-cycle valid strobe and a
// saturation (overflow) flag.
// Optional build macro: EDGE_CNT_HOLDOFF_EN -- when defined, an accepted pulse
// masks pulse_in for the following HOLDOFF_CYCLES cycles.
module edge_window_counter #(
    parameter int WINDOW_CYCLES  = 1000,
    parameter int CNT_WIDTH      = 8,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pulse_in,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 count_valid,
    output logic                 overflow_out,
    output logic                 busy
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t                 state_r, state_s;
    logic [WIN_W-1:0]       win_r, win_s;
    logic [CNT_WIDTH-1:0]   evt_r, evt_s;
    logic                   ovf_r, ovf_s;
    logic [CNT_WIDTH-1:0]   count_out_r, count_out_s;
    logic                   overflow_out_r, overflow_out_s;
    logic                   count_valid_r, count_valid_s;
    logic                   busy_r, busy_s;
    logic [CNT_WIDTH-1:0]   evt_inc_s;
    logic                   ovf_hit_s;
    logic                   pulse_acc_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] value,
        input logic                 inc
    );
        if (inc && (value != CNT_MAX)) begin
            return value + CNT_WIDTH'(1);
        end else begin
            return value;
        end
    endfunction

`ifdef EDGE_CNT_HOLDOFF_EN
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    logic [HOLD_W-1:0] hold_r, hold_s;

    // Holdoff down-counter: armed by an accepted pulse, runs across windows.
    always_comb begin
        hold_s      = hold_r;
        pulse_acc_s = pulse_in && (hold_r == HOLD_W'(0));
        if (!enable) begin
            hold_s = HOLD_W'(0);
        end else if (pulse_acc_s) begin
            hold_s = HOLD_W'(HOLDOFF_CYCLES);
        end else if (hold_r != HOLD_W'(0)) begin
            hold_s = hold_r - HOLD_W'(1);
        end else begin
            hold_s = hold_r;
        end
    end

    // Holdoff register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r <= HOLD_W'(0);
        end else begin
            hold_r <= hold_s;
        end
    end
`else
    // Without holdoff every pulse in an enabled cycle is accepted.
    always_comb begin
        pulse_acc_s = pulse_in;
    end
`endif

    // Next-state, window/event counting and published-result logic.
    always_comb begin
        state_s        = state_r;
        win_s          = win_r;
        evt_s          = evt_r;
        ovf_s          = ovf_r;
        count_out_s    = count_out_r;
        overflow_out_s = overflow_out_r;
        count_valid_s  = 1'b0;
        evt_inc_s      = sat_inc(evt_r, pulse_acc_s);
        ovf_hit_s      = pulse_acc_s && (evt_r == CNT_MAX);

        case (state_r)
            IDLE, COUNT: state_s = enable ? COUNT : IDLE;
            default:     state_s = IDLE;
        endcase

        if (!enable) begin
            // Abort or stay idle: partial window is discarded, results hold.
            win_s = WIN_W'(0);
            evt_s = CNT_WIDTH'(0);
            ovf_s = 1'b0;
        end else if (win_r == WIN_LAST) begin
            // Last cycle of the window: its own pulse is included.
            count_out_s    = evt_inc_s;
            overflow_out_s = ovf_r | ovf_hit_s;
            count_valid_s  = 1'b1;
            win_s          = WIN_W'(0);
            evt_s          = CNT_WIDTH'(0);
            ovf_s          = 1'b0;
        end else begin
            win_s = win_r + WIN_W'(1);
            evt_s = evt_inc_s;
            ovf_s = ovf_r | ovf_hit_s;
        end

        busy_s = (state_s == COUNT);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            win_r          <= WIN_W'(0);
            evt_r          <= CNT_WIDTH'(0);
            ovf_r          <= 1'b0;
            count_out_r    <= CNT_WIDTH'(0);
            overflow_out_r <= 1'b0;
            count_valid_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            win_r          <= win_s;
            evt_r          <= evt_s;
            ovf_r          <= ovf_s;
            count_out_r    <= count_out_s;
            overflow_out_r <= overflow_out_s;
            count_valid_r  <= count_valid_s;
            busy_r         <= busy_s;
        end
    end

    assign count_out    = count_out_r;
    assign count_valid  = count_valid_r;
    assign overflow_out = overflow_out_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_edge_window_counter.sv
// Self-checking bench for edge_window_counter (WINDOW_CYCLES=16, CNT_WIDTH=2).
// A reference model tracks the window position and the unsaturated number of
// accepted pulses; the published count is min(pulses, max) and overflow is
// pulses > max. Holdoff is modelled by the time of the last accepted pulse.
module tb_edge_window_counter;

    localparam int WIN  = 16;
    localparam int CW   = 2;
    localparam int HOLD = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          pulse_in;
    logic [CW-1:0] count_out;
    logic          count_valid;
    logic          overflow_out;
    logic          busy;

    always #5 clk = ~clk;

    edge_window_counter #(
        .WINDOW_CYCLES (WIN),
        .CNT_WIDTH     (CW),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .count_out   (count_out),
        .count_valid (count_valid),
        .overflow_out(overflow_out),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int     m_pos      = 0;
    int     m_pulses   = 0;
    longint m_time     = 0;
    longint m_last_acc = 0;
    bit     m_has_acc  = 1'b0;
    int     exp_valid  = 0;
    int     exp_count  = 0;
    int     exp_ovf    = 0;
    int     exp_busy   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit p);
        bit acc;
        exp_valid = 0;
        if (r) begin
            m_pos = 0; m_pulses = 0; m_has_acc = 1'b0;
            exp_count = 0; exp_ovf = 0; exp_busy = 0;
        end else if (!e) begin
            m_pos = 0; m_pulses = 0; m_has_acc = 1'b0;
            exp_busy = 0;
        end else begin
            acc = p;
`ifdef EDGE_CNT_HOLDOFF_EN
            if (m_has_acc && (m_time - m_last_acc <= HOLD)) acc = 1'b0;
`endif
            if (acc) begin
                m_has_acc  = 1'b1;
                m_last_acc = m_time;
                m_pulses++;
            end
            if (m_pos == WIN - 1) begin
                exp_valid = 1;
                exp_count = (m_pulses > MAXV) ? MAXV : m_pulses;
                exp_ovf   = (m_pulses > MAXV) ? 1 : 0;
                m_pos     = 0;
                m_pulses  = 0;
            end else begin
                m_pos++;
            end
            exp_busy = 1;
        end
        m_time++;
    endtask

    // One clock: drive inputs, advance the model, compare #1 after the edge.
    task automatic step(input bit r, input bit e, input bit p);
        reset    = r;
        enable   = e;
        pulse_in = p;
        @(posedge clk);
        model_step(r, e, p);
        #1;
        check("valid", count_valid, exp_valid);
        check("count", count_out, exp_count);
        check("ovf",   overflow_out, exp_ovf);
        check("busy",  busy, exp_busy);
    endtask

    // One full enabled window; mask bit i puts a pulse on window cycle i.
    task automatic run_window(input logic [WIN-1:0] mask);
        for (int i = 0; i < WIN; i++) begin
            step(1'b0, 1'b1, mask[i]);
            if (i == 0) check("strobe_one_cycle", count_valid, 0);
        end
        check("window_valid", count_valid, 1);
    endtask

    logic [WIN-1:0] mask_v;
    int             exp_c;

    initial begin
        reset = 1'b1; enable = 1'b1; pulse_in = 1'b0;

        // Reset dominates enable and pulses
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, i[0]);
            check("rst_count", count_out, 0);
            check("rst_valid", count_valid, 0);
            check("rst_ovf",   overflow_out, 0);
            check("rst_busy",  busy, 0);
        end
        step(1'b0, 1'b0, 1'b1);

        // Basic window: pulses on 2, 7, 11
        mask_v = '0; mask_v[2] = 1'b1; mask_v[7] = 1'b1; mask_v[11] = 1'b1;
        run_window(mask_v);
`ifdef EDGE_CNT_HOLDOFF_EN
        exp_c = 2;
`else
        exp_c = 3;
`endif
        check("basic_count", count_out, exp_c);
        check("basic_ovf", overflow_out, 0);

        // Boundary: pulse on last cycle, then on first cycle of next window
        mask_v = '0; mask_v[WIN-1] = 1'b1;
        run_window(mask_v);
        check("boundary_last", count_out, 1);
        mask_v = '0; mask_v[0] = 1'b1;
        run_window(mask_v);
`ifdef EDGE_CNT_HOLDOFF_EN
        exp_c = 0;
`else
        exp_c = 1;
`endif
        check("boundary_first", count_out, exp_c);

        // Saturation
        mask_v = '0;
`ifdef EDGE_CNT_HOLDOFF_EN
        mask_v[0] = 1'b1; mask_v[5] = 1'b1; mask_v[10] = 1'b1; mask_v[15] = 1'b1;
`else
        mask_v[1] = 1'b1; mask_v[3] = 1'b1; mask_v[5] = 1'b1; mask_v[8] = 1'b1; mask_v[12] = 1'b1;
`endif
        run_window(mask_v);
        check("sat_count", count_out, 3);
        check("sat_ovf", overflow_out, 1);
        mask_v = '0; mask_v[4] = 1'b1;
        run_window(mask_v);
        check("sat_next_count", count_out, 1);
        check("sat_next_ovf", overflow_out, 0);

        // Abort at window cycle 8
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, (i == 1 || i == 4));
        step(1'b0, 1'b0, 1'b1);
        check("abort_valid", count_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_hold", count_out, 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        mask_v = '0;
        run_window(mask_v);
        check("reenable_count", count_out, 0);

        // Holdoff: pulses on 0, 2, 5 from idle
        step(1'b0, 1'b0, 1'b0);
        mask_v = '0; mask_v[0] = 1'b1; mask_v[2] = 1'b1; mask_v[5] = 1'b1;
        run_window(mask_v);
`ifdef EDGE_CNT_HOLDOFF_EN
        exp_c = 2;
`else
        exp_c = 3;
`endif
        check("holdoff_count", count_out, exp_c);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
